uart_rx: RTL and testbench

- 8N1 UART receiver; the receiving end of the serial link paced by the team's baud clock generator.
- Oversamples the asynchronous rx line at OVERSAMPLE x BAUD_RATE using an internal tick divider, mid-bit samples each bit and reassembles the byte LSB first.
- Delivers each byte as a one-cycle valid pulse to the host-side logic, and flags framing errors.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and elaboration-time
// helpers for baud divisors and counter widths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
      else result = result;
    end
    return result;
  endfunction

  // Counter width that never collapses to zero bits when only one state exists.
  function automatic int width_of(input int count);
    return (clog2(count) < 1) ? 1 : clog2(count);
  endfunction

  function automatic int divisor(input int clock_freq, input int baud_rate, input int oversample);
    return clock_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running clock divider emitting a one-cycle tick at terminal count; a
// synchronous clear restarts the phase so ticks line up with a line event.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIVISOR = 651
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = width_of(DIVISOR);
  localparam logic [W-1:0] LAST = W'(DIVISOR - 1);
  localparam logic [W-1:0] ONE  = W'(32'd1);

  logic [W-1:0] count;

  // Divider count register with phase clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count <= '0;
    else if (clear) count <= '0;
    else if (count == LAST) count <= '0;
    else count <= count + ONE;
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, oversamples with a phase-aligned tick,
// samples mid-bit LSB first and reports good bytes or framing errors as pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int DIVISOR = divisor(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SW = width_of(OVERSAMPLE);
  localparam int BW = width_of(DATA_BITS + 1);
  localparam logic [SW-1:0] MID   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SLAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SONE  = SW'(32'd1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BONE  = BW'(32'd1);

  uart_state_e          state, state_next;
  logic                 rx_meta, rx_s;
  logic                 tick, clear;
  logic [SW-1:0]        sample_cnt, sample_next, sample_inc;
  logic [BW-1:0]        bit_cnt, bit_next;
  logic [DATA_BITS-1:0] shreg, shreg_next, data_next;
  logic                 valid_next, ferr_next;

  uart_baud_tick #(.DIVISOR(DIVISOR)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .tick  (tick)
  );

  // Two-flop synchroniser; idles high like the line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign sample_inc = (sample_cnt == SLAST) ? '0 : sample_cnt + SONE;

  // Next-state and datapath decode. After the start bit the sample counter is
  // re-zeroed at mid-bit, so later mid-bit points fall on its wrap.
  always_comb begin
    state_next  = state;
    sample_next = sample_cnt;
    bit_next    = bit_cnt;
    shreg_next  = shreg;
    data_next   = data_out;
    valid_next  = 1'b0;
    ferr_next   = 1'b0;
    clear       = 1'b0;
    case (state)
      ST_IDLE: begin
        sample_next = '0;
        bit_next    = '0;
        if (!rx_s) begin
          state_next = ST_START;
          clear      = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick && sample_cnt == MID) begin
          sample_next = '0;
          state_next  = rx_s ? ST_IDLE : ST_DATA;
        end else if (tick) begin
          sample_next = sample_inc;
        end else begin
          state_next = ST_START;
        end
      end
      ST_DATA: begin
        if (tick && sample_cnt == SLAST) begin
          sample_next = sample_inc;
          shreg_next  = {rx_s, shreg[DATA_BITS-1:1]};
          bit_next    = bit_cnt + BONE;
          state_next  = (bit_cnt == BLAST) ? ST_STOP : ST_DATA;
        end else if (tick) begin
          sample_next = sample_inc;
        end else begin
          state_next = ST_DATA;
        end
      end
      ST_STOP: begin
        if (tick && sample_cnt == SLAST) begin
          sample_next = sample_inc;
          if (rx_s) begin
            data_next  = shreg;
            valid_next = 1'b1;
            state_next = ST_IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = ST_BREAK;
          end
        end else if (tick) begin
          sample_next = sample_inc;
        end else begin
          state_next = ST_STOP;
        end
      end
      ST_BREAK: begin
        state_next = rx_s ? ST_IDLE : ST_BREAK;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered host-side outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      sample_cnt  <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      sample_cnt  <= sample_next;
      bit_cnt     <= bit_next;
      shreg       <= shreg_next;
      data_out    <= data_next;
      data_valid  <= valid_next;
      frame_error <= ferr_next;
      busy        <= (state_next != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx at a scaled-down baud divisor; frames
// are serialised from byte values and a monitor pops expected pulses.
module tb_uart_rx;

  localparam int CLK_HZ = 640_000;
  localparam int BAUD   = 10_000;
  localparam int OS     = 16;
  localparam int DB     = 8;
  localparam int DIV    = CLK_HZ / (BAUD * OS);
  localparam int BIT    = DIV * OS;
  localparam int LAT    = 2 + (1 + DB) * OS * DIV + (OS / 2) * DIV;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx = 1'b1;
  logic [DB-1:0] data_out;
  logic          data_valid, frame_error, busy;

  uart_rx #(
    .CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(DB)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .data_out(data_out),
    .data_valid(data_valid), .frame_error(frame_error), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_err;
    logic [DB-1:0] data;
  } exp_t;

  exp_t  exp_q[$];
  string chk_name[$];
  int    chk_act[$], chk_exp[$], chk_tol[$];

  int tests = 0, fails = 0;
  int cyc = 0, valid_cyc = 0, n_valid = 0;
  logic [DB-1:0] model_last = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic compare(input string name, input int act, input int exp, input int tol);
    int diff;
    diff = act - exp;
    if (diff < 0) diff = -diff;
    tests++;
    if (diff > tol) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) tol %0d at cycle %0d",
               name, act, act, exp, exp, tol, cyc);
    end
  endtask

  task automatic post(input string name, input int act, input int exp, input int tol);
    chk_name.push_back(name);
    chk_act.push_back(act);
    chk_exp.push_back(exp);
    chk_tol.push_back(tol);
  endtask

  // Monitor: evaluates posted checks and scores every output pulse.
  always @(negedge clk) begin
    exp_t e;
    while (chk_name.size() > 0)
      compare(chk_name.pop_front(), chk_act.pop_front(), chk_exp.pop_front(), chk_tol.pop_front());
    if (data_valid || frame_error) begin
      compare("pulse_exclusive", int'(data_valid && frame_error), 0, 0);
      if (exp_q.size() == 0) begin
        compare("unexpected_pulse", int'({data_valid, frame_error}), 0, 0);
      end else begin
        e = exp_q.pop_front();
        compare("pulse_kind_ferr", int'(frame_error), int'(e.is_err), 0);
        compare("data_out", int'(data_out), int'(e.data), 0);
        compare("busy_at_pulse", int'(busy), int'(e.is_err), 0);
        if (data_valid) begin
          valid_cyc = cyc;
          n_valid   = n_valid + 1;
        end
      end
    end
  end

  task automatic bit_hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DB-1:0] b, input logic stop);
    if (stop) begin
      exp_q.push_back('{1'b0, b});
      model_last = b;
    end else begin
      exp_q.push_back('{1'b1, model_last});
    end
    bit_hold(1'b0, BIT);
    for (int i = 0; i < DB; i++) bit_hold(b[i], BIT);
    bit_hold(stop, BIT);
  endtask

  initial begin
    int t0, n0, bc, gap;
    logic [DB-1:0] pat, b;
    logic st;

    reset = 1'b0;
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    post("reset_data_out", int'(data_out), 0, 0);
    post("reset_data_valid", int'(data_valid), 0, 0);
    post("reset_frame_error", int'(frame_error), 0, 0);
    post("reset_busy", int'(busy), 0, 0);
    reset = 1'b1;
    bit_hold(1'b1, BIT);

    // Single frame with start-edge to pulse latency.
    t0 = cyc;
    send(8'h55, 1'b1);
    bit_hold(1'b1, BIT);
    post("latency_55", valid_cyc - t0, LAT, 3);

    // Back-to-back frames, no idle gap.
    send(8'hA5, 1'b1);
    send(8'h3C, 1'b1);
    bit_hold(1'b1, BIT);

    // Short low glitch rejected at mid start bit.
    n0 = n_valid;
    bc = 0;
    rx = 1'b0;
    for (int i = 0; i < 220; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (i == 15) rx = 1'b1;
    end
    post("glitch_busy_cycles", bc, (OS / 2) * DIV, 3);
    post("glitch_no_valid", n_valid - n0, 0, 0);

    // Framing error followed by a held-low line.
    send(8'hFF, 1'b0);
    bit_hold(1'b0, 3 * BIT);
    post("break_busy", int'(busy), 1, 0);
    post("break_data_out_kept", int'(data_out), 8'h3C, 0);
    bit_hold(1'b1, 2 * BIT);
    send(8'h81, 1'b1);
    bit_hold(1'b1, BIT);

    // Reset during bit 4 of 0xC3.
    n0 = n_valid;
    pat = 8'hC3;
    bit_hold(1'b0, BIT);
    for (int i = 0; i < 4; i++) bit_hold(pat[i], BIT);
    rx = pat[4];
    repeat (BIT / 2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    post("midreset_data_out", int'(data_out), 0, 0);
    post("midreset_data_valid", int'(data_valid), 0, 0);
    post("midreset_frame_error", int'(frame_error), 0, 0);
    post("midreset_busy", int'(busy), 0, 0);
    model_last = '0;
    rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    bit_hold(1'b1, BIT);
    send(8'h81, 1'b1);
    bit_hold(1'b1, BIT);
    post("midreset_single_valid", n_valid - n0, 1, 0);

    // Random frames, occasional bad stop bit, random gaps.
    for (int k = 0; k < 16; k++) begin
      b = DB'($urandom);
      st = ($urandom_range(0, 4) != 0);
      send(b, st);
      gap = ($urandom_range(0, 1) == 1) ? $urandom_range(1, BIT) : 0;
      if (!st) gap = gap + BIT;
      if (gap > 0) bit_hold(1'b1, gap);
    end
    bit_hold(1'b1, 2 * BIT);
    post("scoreboard_drained", exp_q.size(), 0, 0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
